tri_bus_arbiter: RTL and testbench
==================================

# tri_bus_arbiter

Round-robin arbiter that shares one tristate bus line among `N` requesters. It drives the per-source tristate enables (`iEna` of each `three_state_gates` instance) so that at most one driver is ever enabled. A forced turnaround gap, with every enable low, separates consecutive owners so drivers never overlap. It sits between the requesting blocks and the bank of tristate drivers on the shared line.

## Interface
Parameters:
- `N`, 4: number of requesters/drivers; legal range 2..16.
- `MAX_HOLD`, 8: maximum consecutive cycles one owner keeps the bus; must be ≥1.
- `TURNAROUND`, 1: dead cycles with all enables low between owners; must be ≥1.

Ports:
- `iClk`  in  1  sole clock; all state updates on the rising edge.
- `iRst`  in  1  synchronous, active-high reset.
- `iReq`  in  N  level request, one bit per requester.
- `oEna`  out  N  one-hot-or-zero tristate enables; bit i drives requester i's `iEna`.
- `oOwner`  out  clog2(N)  index of the current owner; holds the last owner when idle.
- `oBusy`  out  1  high in GRANT and TURN states.

## Operation
- State machine states: IDLE, GRANT, TURN. `oEna`, `oOwner` and `oBusy` are registered.
- Reset values: state IDLE, `oEna`=0, `oOwner`=0, `oBusy`=0, priority pointer=0, hold counter=0, turn counter=0.
- IDLE:
  - If any `iReq` bit is set, pick the winner, set `oEna` to one-hot(winner), set `oOwner` to the winner, go to GRANT.
  - Otherwise stay in IDLE.
- Winner selection: the first set `iReq` bit at or after the pointer, searching upward and wrapping from N-1 to 0. On a grant the pointer becomes (winner+1) mod N.
- GRANT: the hold counter counts owner cycles, starting at 1 on the grant edge. Go to TURN and clear `oEna` on the same edge when either condition holds:
  - `iReq[oOwner]` is sampled low, or
  - the hold counter equals `MAX_HOLD`.
- Requests from non-owners during GRANT have no effect on the current grant.
- TURN: `oEna`=0 for exactly `TURNAROUND` cycles. On the last TURN cycle, arbitrate as in IDLE:
  - If a request is present, go straight to GRANT.
  - Otherwise go to IDLE.
- A requester still asserting after hitting `MAX_HOLD` is re-eligible. It wins again only if no other requester precedes it in round-robin order.
- Invariant, every cycle: `oEna` is one-hot or zero.
- Invariant: between any two nonzero `oEna` values there are at least `TURNAROUND` cycles of `oEna`=0, even when the same owner is re-granted.

## Timing
- Request-to-enable latency: 1 cycle. `iReq` sampled high at edge k means `oEna` is set after edge k.
- Release latency: 1 cycle. The edge that samples `iReq[owner]` low clears `oEna`.
- A continuous single requester with defaults gets 8 enabled cycles, then 1 dead cycle, repeating.
- A request that drops during TURN is not granted.
- A request that arrives during TURN is granted on the edge that ends TURN.
- Reset mid-operation: `iRst` high at edge k clears all outputs after edge k, regardless of state. The next grant searches from requester 0.
- Simultaneous release and `MAX_HOLD` expiry: a single transition to TURN.

## Structure
- Shared package/include `tri_arb_pkg` holds:
  - state encoding constants (IDLE=0, GRANT=1, TURN=2);
  - the clog2 width helper used by `oOwner` and the counters.
- One combinational sub-module, `rr_priority_pick`. Inputs: `iReq[N]` and the pointer. Outputs: a one-hot winner and its index. Reusable by later schedulers.
- Estimated size: FSM plus counters ~150 lines, picker ~60 lines.

## Test plan
- Single requester, defaults, `iReq`=0001 held. Expect `oEna`=0001 from the cycle after the request, for 8 cycles, then 0000 for 1 cycle, then 0001 again.
- All requesting, `iReq`=1111 held. Expect owners in order 0,1,2,3,0, each enabled for 8 cycles, with exactly one 0000 cycle between owners.
- Early release. `iReq`=0010 for 3 cycles, then 0. Expect `oEna`=0010 for 3 cycles, 0000 in TURN, then IDLE with `oBusy`=0.
- Reset mid-grant. While requester 2 owns the bus, pulse `iRst` for one cycle with `iReq`=1111. Expect all outputs 0 on the next cycle, then requester 0 granted first.
- Parameter variant `TURNAROUND`=3, `MAX_HOLD`=2 with `iReq`=0101. Expect owner 0 for 2 cycles, 3 zero cycles, owner 2 for 2 cycles, and so on.
- Throughout all tests, a checker flags any non-one-hot nonzero `oEna` and any owner change with fewer than `TURNAROUND` zero cycles between.

Source files
------------

// File: rtl/tri_arb_pkg.sv
// Shared encodings and width helper for the tristate bus arbiter and its picker.
// Pure declarations: no logic, no latency, no flow control.
`timescale 1ns/1ps
package tri_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arbState_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int clog2W(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin picker: first set request at or above the pointer, wrapping at N-1.
// Purely combinational, zero latency; no backpressure.
`timescale 1ns/1ps
module rr_priority_pick
    import tri_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2W(N)
) (
    input  logic [N-1:0] iReq,
    input  logic [W-1:0] iPtr,
    output logic [N-1:0] oGrant,
    output logic [W-1:0] oIdx,
    output logic         oValid
);

    int j;

    always_comb begin
        oGrant = '0;
        oIdx   = '0;
        oValid = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(iPtr) + k) % N;
            if (!oValid && iReq[j]) begin
                oValid    = 1'b1;
                oGrant[j] = 1'b1;
                oIdx      = W'(j);
            end
        end
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of a shared tristate line with a forced all-off turnaround between owners.
// Latency: 1 cycle request-to-enable and release-to-off; no backpressure, requests are levels.
`timescale 1ns/1ps
module tri_bus_arbiter
    import tri_arb_pkg::*;
#(
    parameter int N          = 4,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic [N-1:0]         iReq,
    output logic [N-1:0]         oEna,
    output logic [clog2W(N)-1:0] oOwner,
    output logic                 oBusy
);

    localparam int OW = clog2W(N);
    localparam int HW = clog2W(MAX_HOLD + 1);
    localparam int TW = clog2W(TURNAROUND + 1);

    arbState_t        state;
    arbState_t        stateNext;
    logic [OW-1:0]    ptr;
    logic [OW-1:0]    ptrNext;
    logic [HW-1:0]    holdCnt;
    logic [HW-1:0]    holdNext;
    logic [TW-1:0]    turnCnt;
    logic [TW-1:0]    turnNext;
    logic [N-1:0]     enaNext;
    logic [OW-1:0]    ownerNext;
    logic             busyNext;

    logic [N-1:0]     pickGrant;
    logic [OW-1:0]    pickIdx;
    logic             pickValid;
    logic [OW-1:0]    pickPtrNext;

    logic             ownerReq;
    logic             holdDone;
    logic             turnDone;
    logic             release_;
    logic             arbitrate;

    rr_priority_pick #(
        .N (N),
        .W (OW)
    ) uPick (
        .iReq   (iReq),
        .iPtr   (ptr),
        .oGrant (pickGrant),
        .oIdx   (pickIdx),
        .oValid (pickValid)
    );

    assign ownerReq    = iReq[oOwner];
    assign holdDone    = (holdCnt == HW'(MAX_HOLD));
    assign turnDone    = (turnCnt == TW'(TURNAROUND));
    assign release_    = !ownerReq || holdDone;
    assign arbitrate   = (state == IDLE) || ((state == TURN) && turnDone);
    assign pickPtrNext = (pickIdx == OW'(N - 1)) ? '0 : pickIdx + OW'(1);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            ptr     <= '0;
            holdCnt <= '0;
            turnCnt <= '0;
            oEna    <= '0;
            oOwner  <= '0;
            oBusy   <= 1'b0;
        end else begin
            state   <= stateNext;
            ptr     <= ptrNext;
            holdCnt <= holdNext;
            turnCnt <= turnNext;
            oEna    <= enaNext;
            oOwner  <= ownerNext;
            oBusy   <= busyNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = pickValid ? GRANT : IDLE;
            GRANT:   stateNext = release_ ? TURN : GRANT;
            TURN:    if (turnDone) stateNext = pickValid ? GRANT : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Owner-facing registers; a TURN exit re-arbitrates exactly like IDLE.
    always_comb begin
        enaNext   = oEna;
        ownerNext = oOwner;
        busyNext  = oBusy;
        ptrNext   = ptr;
        holdNext  = holdCnt;
        turnNext  = turnCnt;
        case (state)
            GRANT: begin
                if (release_) begin
                    enaNext  = '0;
                    turnNext = TW'(1);
                    busyNext = 1'b1;
                end else begin
                    holdNext = holdCnt + HW'(1);
                end
            end
            TURN: begin
                if (!turnDone) begin
                    turnNext = turnCnt + TW'(1);
                end
            end
            default: begin
            end
        endcase
        if (arbitrate) begin
            turnNext = '0;
            if (pickValid) begin
                enaNext   = pickGrant;
                ownerNext = pickIdx;
                ptrNext   = pickPtrNext;
                holdNext  = HW'(1);
                busyNext  = 1'b1;
            end else begin
                enaNext  = '0;
                busyNext = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: default instance plus a TURNAROUND=3 / MAX_HOLD=2 variant, checked against a behavioural model.
`timescale 1ns/1ps
module tb_tri_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req0, req1;
    logic [3:0] ena0, ena1;
    logic [1:0] own0, own1;
    logic       busy0, busy1;

    int tests = 0;
    int fails = 0;

    tri_bus_arbiter #(.N(4), .MAX_HOLD(8), .TURNAROUND(1)) dut0 (
        .iClk(clk), .iRst(rst), .iReq(req0), .oEna(ena0), .oOwner(own0), .oBusy(busy0)
    );

    tri_bus_arbiter #(.N(4), .MAX_HOLD(2), .TURNAROUND(3)) dut1 (
        .iClk(clk), .iRst(rst), .iReq(req1), .oEna(ena1), .oOwner(own1), .oBusy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner (-1 when nobody holds the bus), cycles held, dead cycles left.
    int mMax[2]  = '{8, 2};
    int mTurn[2] = '{1, 3};
    int mOwn[2], mHeld[2], mDead[2], mPtr[2], mLast[2];
    int gap[2], prevEna[2], hadGrant[2];

    task automatic checkEq(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic stepModel(input int i, input logic [3:0] r, input logic rs);
        int w;
        if (rs) begin
            mOwn[i] = -1; mHeld[i] = 0; mDead[i] = 0; mPtr[i] = 0; mLast[i] = 0;
        end else if (mOwn[i] >= 0) begin
            if (!r[mOwn[i]] || mHeld[i] == mMax[i]) begin
                mOwn[i]  = -1;
                mDead[i] = mTurn[i];
            end else begin
                mHeld[i]++;
            end
        end else if (mDead[i] > 1) begin
            mDead[i]--;
        end else begin
            mDead[i] = 0;
            w = -1;
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && r[(mPtr[i] + k) % 4]) w = (mPtr[i] + k) % 4;
            end
            if (w >= 0) begin
                mOwn[i] = w; mLast[i] = w; mHeld[i] = 1; mPtr[i] = (w + 1) % 4;
            end
        end
    endtask

    task automatic compareInst(input int i, input logic [3:0] ena, input logic [1:0] own,
                               input logic busy, input logic rs);
        int e;
        e = int'(ena);
        checkEq($sformatf("ena%0d", i), e, (mOwn[i] >= 0) ? (1 << mOwn[i]) : 0);
        checkEq($sformatf("owner%0d", i), int'(own), mLast[i]);
        checkEq($sformatf("busy%0d", i), int'(busy), (mOwn[i] >= 0 || mDead[i] > 0) ? 1 : 0);
        checkEq($sformatf("onehot%0d", i), int'($onehot0(ena)), 1);
        if (rs) begin
            hadGrant[i] = 0; gap[i] = 0;
        end else if (e != 0) begin
            if (prevEna[i] == 0 && hadGrant[i] != 0)
                checkEq($sformatf("gap%0d", i), int'(gap[i] >= mTurn[i]), 1);
            if (prevEna[i] != 0 && prevEna[i] != e)
                checkEq($sformatf("swap%0d", i), e, prevEna[i]);
            gap[i] = 0; hadGrant[i] = 1;
        end else begin
            gap[i]++;
        end
        prevEna[i] = e;
    endtask

    task automatic cyc(input logic [3:0] r0, input logic [3:0] r1, input logic rs);
        req0 = r0; req1 = r1; rst = rs;
        @(posedge clk);
        stepModel(0, r0, rs);
        stepModel(1, r1, rs);
        #1;
        compareInst(0, ena0, own0, busy0, rs);
        compareInst(1, ena1, own1, busy1, rs);
    endtask

    initial begin
        logic [3:0] r0, r1;
        int len, expV;
        for (int i = 0; i < 2; i++) begin
            mOwn[i] = -1; mHeld[i] = 0; mDead[i] = 0; mPtr[i] = 0; mLast[i] = 0;
            gap[i] = 0; prevEna[i] = 0; hadGrant[i] = 0;
        end

        cyc(4'b0000, 4'b0000, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1);
        checkEq("rstEna", int'(ena0), 0);
        checkEq("rstOwner", int'(own0), 0);
        checkEq("rstBusy", int'(busy0), 0);

        // Single requester on defaults; 0101 on the short-hold, long-turnaround variant.
        for (int c = 1; c <= 12; c++) begin
            cyc(4'b0001, 4'b0101, 1'b0);
            checkEq("single", int'(ena0), (c == 9) ? 0 : 1);
            expV = ((c - 1) % 5 < 2) ? ((((c - 1) / 5) % 2 == 0) ? 1 : 4) : 0;
            checkEq("variant", int'(ena1), expV);
        end

        // Early release.
        cyc(4'b0000, 4'b0000, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            cyc((c <= 3) ? 4'b0010 : 4'b0000, 4'b0000, 1'b0);
            checkEq("release", int'(ena0), (c <= 3) ? 2 : 0);
            checkEq("relBusy", int'(busy0), (c <= 4) ? 1 : 0);
        end

        // All requesting, reset while requester 2 owns, then full rotation from 0.
        cyc(4'b0000, 4'b0000, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            cyc(4'b1111, 4'($urandom_range(0, 15)), 1'b0);
            checkEq("rrPre", int'(ena0), (c % 9 == 0) ? 0 : (1 << (((c - 1) / 9) % 4)));
        end
        checkEq("preRstOwner", int'(own0), 2);
        cyc(4'b1111, 4'($urandom_range(0, 15)), 1'b1);
        checkEq("midRstEna", int'(ena0), 0);
        checkEq("midRstOwner", int'(own0), 0);
        checkEq("midRstBusy", int'(busy0), 0);
        for (int c = 1; c <= 45; c++) begin
            cyc(4'b1111, 4'($urandom_range(0, 15)), 1'b0);
            checkEq("rrOrder", int'(ena0), (c % 9 == 0) ? 0 : (1 << (((c - 1) / 9) % 4)));
            if (c % 9 != 0) checkEq("rrOwner", int'(own0), ((c - 1) / 9) % 4);
        end

        // Random phases with occasional bit flips and reset pulses.
        for (int p = 0; p < 200; p++) begin
            r0  = 4'($urandom_range(0, 15));
            r1  = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 20);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 5) == 0) r0[$urandom_range(0, 3)] ^= 1'b1;
                if ($urandom_range(0, 5) == 0) r1[$urandom_range(0, 3)] ^= 1'b1;
                cyc(r0, r1, ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
